// File: rtl/pulse_arbiter_if.sv
// Handshake bundle between pulse_arbiter, its requesters and the shared pulse generator.
// master: arbiter side; slave: requester/generator side.
interface pulse_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic               gen_start;
  logic               gen_sig;
  logic               busy;
  logic               timeout_err;

  modport master (
    input  req, gen_sig,
    output grant, done, gen_start, busy, timeout_err
  );

  modport slave (
    output req, gen_sig,
    input  grant, done, gen_start, busy, timeout_err
  );
endinterface

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter sharing one pulse generator among NUM_REQ requesters.
// Optional watchdog on the generator handshake: define PULSE_ARB_TIMEOUT_EN.
module pulse_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  pulse_arbiter_if.master   arb
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, LAUNCH, ARMED, ACTIVE, DONE} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               gen_start_q, gen_start_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;

  // First set request at or above ptr_q, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      logic [PTR_W-1:0] sel;
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = idx[PTR_W-1:0];
      if (!pick_vld && arb.req[sel]) begin
        pick_vld = 1'b1;
        pick_idx = sel;
      end
    end
  end

`ifdef PULSE_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    gen_start_d = 1'b0;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
`ifdef PULSE_ARB_TIMEOUT_EN
    cnt_d       = '0;
    tmo_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = LAUNCH;
          owner_d     = pick_idx;
          grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          gen_start_d = 1'b1;
        end
      end
      LAUNCH: state_d = ARMED;
      ARMED: begin
        if (arb.gen_sig) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!arb.gen_sig) begin
          state_d = DONE;
          done_d  = grant_q;
          grant_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
      end
      default: state_d = IDLE;
    endcase
`ifdef PULSE_ARB_TIMEOUT_EN
    // Watchdog overrides the normal ARMED/ACTIVE transitions when it expires.
    if (state_q == ARMED || state_q == ACTIVE) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        done_d  = grant_q;
        grant_d = '0;
        tmo_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      gen_start_q <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= '0;
`ifdef PULSE_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      gen_start_q <= gen_start_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
`ifdef PULSE_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign arb.grant     = grant_q;
  assign arb.done      = done_q;
  assign arb.gen_start = gen_start_q;
  assign arb.busy      = (state_q != IDLE);
`ifdef PULSE_ARB_TIMEOUT_EN
  assign arb.timeout_err = tmo_q;
`else
  assign arb.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_arbiter.sv
// Self-checking bench for pulse_arbiter with a width-3 pulse generator model.
module tb_pulse_arbiter;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pulse_arbiter_if #(.NUM_REQ(N)) bus ();

  pulse_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  always #5 clk = ~clk;

  // Pulse generator: sig high for 3 cycles after a start strobe; shares rst.
  int unsigned gcnt;
  bit          force_low = 1'b0;
  always @(posedge clk) begin
    if (rst) gcnt <= 0;
    else if (bus.gen_start) gcnt <= 3;
    else if (gcnt != 0) gcnt <= gcnt - 1;
  end
  assign bus.gen_sig = (gcnt != 0) && !force_low;

  int          checks = 0;
  int          errors = 0;
  int unsigned mptr   = 0;

  function automatic int unsigned rr_pick(logic [N-1:0] r, int unsigned p);
    logic [N-1:0] rv;
    rv = r;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned k;
      k = (p + i) % N;
      if (rv[k]) return k;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.grant != '0) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.done != '0) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    force_low = 1'b0;
    step();
    step();
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    step();
    step();
    checks++;
    if ({bus.grant, bus.done, bus.gen_start, bus.busy, bus.timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b done=%b start=%b busy=%b tmo=%b, want all 0",
               bus.grant, bus.done, bus.gen_start, bus.busy, bus.timeout_err);
    end
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_single();
    int hi, fell, dcyc;
    bit got, unstable;
    bus.req = 4'b0100;
    step();
    checks++;
    if (bus.grant !== 4'b0100 || bus.gen_start !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b start=%b, want 0100/1", bus.grant, bus.gen_start);
    end
    step();
    checks++;
    if (bus.grant !== 4'b0100 || bus.gen_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_width: grant=%b start=%b, want 0100/0", bus.grant, bus.gen_start);
    end
    hi = bus.gen_sig ? 1 : 0;
    fell = -1; dcyc = -1; got = 1'b0; unstable = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.gen_sig) hi++;
      else if (hi > 0 && fell < 0) fell = i;
      if (bus.done != '0) begin
        got = 1'b1;
        dcyc = i;
        break;
      end
      if (bus.grant !== 4'b0100) unstable = 1'b1;
    end
    checks++;
    if (!got || bus.done !== 4'b0100) begin
      errors++;
      $display("FAIL single_done: done=%b seen=%0d, want 0100", bus.done, got);
    end
    checks++;
    if (hi != 3 || dcyc - fell != 1 || unstable) begin
      errors++;
      $display("FAIL single_timing: sig_high=%0d done-fall=%0d unstable=%0d, want 3/1/0",
               hi, dcyc - fell, unstable);
    end
    bus.req = '0;
    mptr = 3;
    step();
    checks++;
    if (bus.done !== '0 || bus.grant !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: done=%b grant=%b busy=%b, want 0/0/0", bus.done, bus.grant, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int n; bit ok;
    logic [N-1:0] exp;
    int unsigned w;
    do_reset();
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      w = rr_pick(bus.req, mptr);
      exp = '0;
      exp[w] = 1'b1;
      wait_grant(n, ok);
      checks++;
      if (!ok || bus.grant !== exp || (t > 0 && n != 2) || (t == 0 && n != 1)) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b after %0d cycles, want %b after %0d",
                 t, bus.grant, n, exp, (t == 0) ? 1 : 2);
      end
      wait_done(n, ok);
      checks++;
      if (!ok || bus.done !== exp || n != 5) begin
        errors++;
        $display("FAIL rr_done%0d: done=%b after %0d cycles, want %b after 5", t, bus.done, n, exp);
      end
      mptr = (w + 1) % N;
    end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_drop();
    int n; bit ok;
    do_reset();
    bus.req = 4'b0010;
    wait_grant(n, ok);
    checks++;
    if (!ok || bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL drop_grant: grant=%b, want 0010", bus.grant);
    end
    step();
    bus.req = '0;
    wait_done(n, ok);
    checks++;
    if (!ok || bus.done !== 4'b0010) begin
      errors++;
      $display("FAIL drop_done: done=%b seen=%0d, want 0010", bus.done, ok);
    end
    step();
    checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.done !== '0) begin
      errors++;
      $display("FAIL drop_idle: grant=%b busy=%b done=%b, want 0/0/0", bus.grant, bus.busy, bus.done);
    end
    mptr = 2;
  endtask

  task automatic test_reset_mid();
    int n; bit ok, saw_done;
    do_reset();
    bus.req = 4'b0100;
    wait_grant(n, ok);
    step();
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.gen_sig !== 1'b1 || bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_active: busy=%b sig=%b grant=%b, want 1/1/0100", bus.busy, bus.gen_sig, bus.grant);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({bus.grant, bus.done, bus.gen_start, bus.busy, bus.timeout_err} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: grant=%b done=%b start=%b busy=%b tmo=%b, want all 0",
               bus.grant, bus.done, bus.gen_start, bus.busy, bus.timeout_err);
    end
    step();
    saw_done = (bus.done != '0);
    rst = 1'b0;
    bus.req = 4'b1001;
    mptr = 0;
    wait_grant(n, ok);
    checks++;
    if (saw_done || !ok || n != 1 || bus.grant !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_regrant: grant=%b after %0d (done_in_rst=%0d), want 0001 after 1",
               bus.grant, n, saw_done);
    end
    wait_done(n, ok);
    bus.req = '0;
    step();
  endtask

  task automatic test_random();
    int n, gs; bit ok, unstable;
    logic [N-1:0] exp;
    int unsigned w;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      bus.req = 4'($urandom_range(1, 15));
      w = rr_pick(bus.req, mptr);
      exp = '0;
      exp[w] = 1'b1;
      wait_grant(n, ok);
      checks++;
      if (!ok || bus.grant !== exp || n != ((t == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL rand_grant%0d: req=%b grant=%b after %0d, want %b", t, bus.req, bus.grant, n, exp);
      end
      gs = bus.gen_start ? 1 : 0;
      if ($urandom_range(0, 1) == 1) bus.req = 4'($urandom_range(0, 15));
      ok = 1'b0; unstable = 1'b0; n = 0;
      for (int i = 1; i <= 30; i++) begin
        step();
        if (bus.gen_start) gs++;
        if (bus.done != '0) begin
          ok = 1'b1;
          n = i;
          break;
        end
        if (bus.grant !== exp) unstable = 1'b1;
      end
      checks++;
      if (!ok || bus.done !== exp || n != 5 || gs != 1 || unstable) begin
        errors++;
        $display("FAIL rand_done%0d: done=%b n=%0d starts=%0d unstable=%0d, want %b/5/1/0",
                 t, bus.done, n, gs, unstable, exp);
      end
      mptr = (w + 1) % N;
    end
    bus.req = '0;
    step();
    step();
  endtask

`ifdef PULSE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit ok;
    do_reset();
    force_low = 1'b1;
    bus.req = 4'b0001;
    wait_grant(n, ok);
    step();
    wait_done(n, ok);
    checks++;
    if (!ok || n != 8 || bus.done !== 4'b0001 || bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: done=%b tmo=%b after %0d, want 0001/1 after 8",
               bus.done, bus.timeout_err, n);
    end
    bus.req = '0;
    step();
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.done !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: tmo=%b done=%b busy=%b, want 0/0/0", bus.timeout_err, bus.done, bus.busy);
    end
    force_low = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    int n, bad; bit ok;
    do_reset();
    force_low = 1'b1;
    bus.req = 4'b0001;
    wait_grant(n, ok);
    bad = ok ? 0 : 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0 || bus.done !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_timeout_hold: %0d bad cycles (busy=%b tmo=%b), want 0", bad, bus.busy, bus.timeout_err);
    end
    do_reset();
  endtask
`endif

  initial begin
    bus.req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_random();
`ifdef PULSE_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
